// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core, sharing one memory port.
// Define MC_PERF_CNT_EN to build the retired-instruction counter driven onto instret.
module mc_control_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int INSTR_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               mem_addr_sel,
   output logic               ir_we,
   output logic               pc_we,
   output logic               RegWE,
   output logic [3:0]         ALU_control,
   output logic               Imm_mux_SEL,
   output logic               WB_sel,
   output logic [2:0]         state,
   output logic               illegal,
   output logic               bus_err,
   output logic [31:0]        instret
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   if (INSTR_W != 32 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_param
      $error("mc_control_fsm: INSTR_W must be 32 and MEM_TIMEOUT must lie in 1..255");
   end

   logic [2:0]  state_q;
   logic [31:0] ir_q;
   logic [7:0]  wait_cnt_q;
   logic [7:0]  wait_cnt_inc;
   logic        illegal_q;
   logic        bus_err_q;
   logic        timed_out;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_r;
   logic        is_i;
   logic        is_load;
   logic        is_store;
   logic        is_legal;
   logic [3:0]  alu_op;
   logic        unused_ir_bits;

   assign opcode         = ir_q[6:0];
   assign funct3         = ir_q[14:12];
   assign is_r           = (opcode == OP_R);
   assign is_i           = (opcode == OP_I);
   assign is_load        = (opcode == OP_LOAD);
   assign is_store       = (opcode == OP_STORE);
   assign is_legal       = is_r || is_i || is_load || is_store;
   assign unused_ir_bits = ^{ir_q[31], ir_q[29:15]};

   // A request times out when this waiting cycle would bring the count up to MEM_TIMEOUT.
   assign wait_cnt_inc = wait_cnt_q + 8'd1;
   assign timed_out    = !mem_ready && (wait_cnt_inc == TIMEOUT_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         ir_q       <= '0;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_q       <= instr;
                  state_q    <= S_DECODE;
                  wait_cnt_q <= '0;
               end else if (timed_out) begin
                  state_q   <= S_TRAP;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_inc;
               end
            end
            S_DECODE: begin
               if (is_legal) begin
                  state_q <= S_EXEC;
               end else begin
                  state_q   <= S_TRAP;
                  illegal_q <= 1'b1;
               end
            end
            S_EXEC: begin
               state_q    <= (is_load || is_store) ? S_MEM : S_WB;
               wait_cnt_q <= '0;
            end
            S_MEM: begin
               if (mem_ready) begin
                  state_q    <= is_store ? S_FETCH : S_WB;
                  wait_cnt_q <= '0;
               end else if (timed_out) begin
                  state_q   <= S_TRAP;
                  bus_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_inc;
               end
            end
            S_WB: begin
               state_q    <= S_FETCH;
               wait_cnt_q <= '0;
            end
            default: state_q <= S_TRAP;
         endcase
      end
   end

   always_comb begin
      alu_op = 4'b0000;
      if (is_r || is_i) begin
         case (funct3)
            3'b000:  alu_op = (is_r && ir_q[30]) ? 4'b0001 : 4'b0000;
            3'b001:  alu_op = 4'b0010;
            3'b010:  alu_op = 4'b0011;
            3'b011:  alu_op = 4'b0100;
            3'b100:  alu_op = 4'b0101;
            3'b101:  alu_op = ir_q[30] ? 4'b0111 : 4'b0110;
            3'b110:  alu_op = 4'b1000;
            default: alu_op = 4'b1001;
         endcase
      end
   end

   // ir_we/pc_we follow mem_ready in FETCH so the IR and PC load on the accepting edge.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      RegWE        = 1'b0;
      ALU_control  = 4'b0000;
      Imm_mux_SEL  = 1'b0;
      WB_sel       = !is_load;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
         end
         S_EXEC: begin
            ALU_control = alu_op;
            Imm_mux_SEL = !is_r;
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_we       = is_store;
            mem_addr_sel = 1'b1;
            ALU_control  = alu_op;
            Imm_mux_SEL  = !is_r;
         end
         S_WB: begin
            RegWE       = (ir_q[11:7] != 5'd0);
            ALU_control = alu_op;
            Imm_mux_SEL = !is_r;
         end
         default: ;
      endcase
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

`ifdef MC_PERF_CNT_EN
   logic [31:0] instret_q;

   // An instruction retires when leaving WB, or leaving MEM on a completed store.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= '0;
      end else if (state_q == S_WB || (state_q == S_MEM && mem_ready && is_store)) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`else
   assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm, built with MEM_TIMEOUT=4.
// Expected behaviour comes from an instruction-level model of fetch/decode/exec/mem/wb timing.
module tb_mc_control_fsm;

   localparam int TMO = 4;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [3:0] F3_OP [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
`ifdef MC_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_ready = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, RegWE;
   logic [3:0]  ALU_control;
   logic        Imm_mux_SEL, WB_sel;
   logic [2:0]  state;
   logic        illegal, bus_err;
   logic [31:0] instret;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_instret = 32'h0;
   logic        exp_illegal = 1'b0;
   logic        exp_bus_err = 1'b0;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_TIMEOUT(TMO), .INSTR_W(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_we(ir_we), .pc_we(pc_we), .RegWE(RegWE), .ALU_control(ALU_control),
      .Imm_mux_SEL(Imm_mux_SEL), .WB_sel(WB_sel), .state(state),
      .illegal(illegal), .bus_err(bus_err), .instret(instret)
   );

   function automatic logic [10:0] observed();
      return {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, RegWE, illegal, bus_err};
   endfunction

   // Expected ALU opcode from the instruction mnemonic rules.
   function automatic logic [3:0] ref_alu(input logic [31:0] ins);
      logic [2:0] f3  = ins[14:12];
      logic [6:0] opc = ins[6:0];
      if (opc == OP_LD || opc == OP_ST) return 4'd0;
      if (f3 == 3'd5 && ins[30]) return 4'd7;
      if (f3 == 3'd0 && opc == OP_R && ins[30]) return 4'd1;
      return F3_OP[f3];
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r   = $urandom;
      logic [1:0]  k   = 2'($urandom_range(0, 3));
      logic [6:0]  opc = (k == 0) ? OP_R : (k == 1) ? OP_I : (k == 2) ? OP_LD : OP_ST;
      return {r[31:7], opc};
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_instret = 32'h0;
      exp_illegal = 1'b0;
      exp_bus_err = 1'b0;
   endtask

   // Runs one instruction from the first FETCH cycle; a trap is then held and checked for 20 cycles.
   task automatic run_instr(input logic [31:0] ins, input int fetch_wait, input int mem_wait);
      logic [6:0]  opc   = ins[6:0];
      logic        is_ld = (opc == OP_LD);
      logic        is_st = (opc == OP_ST);
      logic        legal = (opc == OP_R) || (opc == OP_I) || is_ld || is_st;
      logic [4:0]  dp_exp = {ref_alu(ins), opc != OP_R};
      logic [10:0] exp;
      logic        trapped = 1'b0;
      for (int c = 0; c <= fetch_wait && !trapped; c++) begin
         mem_ready = (c == fetch_wait);
         instr = mem_ready ? ins : $urandom;
         @(negedge clk);
         exp = {3'd0, 3'b100, mem_ready, mem_ready, 1'b0, exp_illegal, exp_bus_err};
         vectors++;
         if (observed() !== exp) begin
            miscompares++;
            $display("[TB] FAIL fetch c%0d ins=%h: got %h want %h", c, ins, observed(), exp);
         end
         if (c == 0) begin
            vectors++;
            if (instret !== (PERF ? exp_instret : 32'h0)) begin
               miscompares++;
               $display("[TB] FAIL instret ins=%h: got %0d want %0d", ins, instret, PERF ? exp_instret : 32'h0);
            end
         end
         if (!mem_ready && c == TMO - 1) begin
            exp_bus_err = 1'b1;
            trapped = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!trapped) begin
         mem_ready = 1'($urandom);
         instr = $urandom;
         @(negedge clk);
         exp = {3'd1, 6'b0, exp_illegal, exp_bus_err};
         vectors++;
         if (observed() !== exp) begin
            miscompares++;
            $display("[TB] FAIL decode ins=%h: got %h want %h", ins, observed(), exp);
         end
         if (!legal) begin
            exp_illegal = 1'b1;
            trapped = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!trapped) begin
         mem_ready = 1'($urandom);
         @(negedge clk);
         exp = {3'd2, 6'b0, exp_illegal, exp_bus_err};
         vectors++;
         if (observed() !== exp || {ALU_control, Imm_mux_SEL} !== dp_exp) begin
            miscompares++;
            $display("[TB] FAIL exec ins=%h: got %h/%h want %h/%h", ins, observed(), {ALU_control, Imm_mux_SEL}, exp, dp_exp);
         end
         @(posedge clk); #1;
      end
      for (int c = 0; c <= mem_wait && !trapped && (is_ld || is_st); c++) begin
         mem_ready = (c == mem_wait);
         @(negedge clk);
         exp = {3'd3, 1'b1, is_st, 1'b1, 3'b000, exp_illegal, exp_bus_err};
         vectors++;
         if (observed() !== exp || {ALU_control, Imm_mux_SEL} !== dp_exp) begin
            miscompares++;
            $display("[TB] FAIL mem c%0d ins=%h: got %h/%h want %h/%h", c, ins, observed(), {ALU_control, Imm_mux_SEL}, exp, dp_exp);
         end
         if (!mem_ready && c == TMO - 1) begin
            exp_bus_err = 1'b1;
            trapped = 1'b1;
         end else if (mem_ready && is_st) begin
            exp_instret = exp_instret + 32'd1;
         end
         @(posedge clk); #1;
      end
      if (!trapped && !is_st) begin
         mem_ready = 1'($urandom);
         @(negedge clk);
         exp = {3'd4, 5'b0, ins[11:7] != 5'd0, exp_illegal, exp_bus_err};
         vectors++;
         if (observed() !== exp || {ALU_control, Imm_mux_SEL, WB_sel} !== {dp_exp, !is_ld}) begin
            miscompares++;
            $display("[TB] FAIL wb ins=%h: got %h/%h want %h/%h", ins, observed(), {ALU_control, Imm_mux_SEL, WB_sel}, exp, {dp_exp, !is_ld});
         end
         exp_instret = exp_instret + 32'd1;
         @(posedge clk); #1;
      end
      for (int c = 0; c < 20 && trapped; c++) begin
         mem_ready = 1'($urandom);
         instr = $urandom;
         @(negedge clk);
         exp = {3'd5, 6'b0, exp_illegal, exp_bus_err};
         vectors++;
         if (observed() !== exp || instret !== (PERF ? exp_instret : 32'h0)) begin
            miscompares++;
            $display("[TB] FAIL trap c%0d ins=%h: got %h cnt %0d want %h cnt %0d", c, ins, observed(), instret, exp, PERF ? exp_instret : 32'h0);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if (observed() !== 11'b000_100_000_00 || instret !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %h cnt %0d want %h cnt 0", observed(), instret, 11'b000_100_000_00);
      end
      apply_reset();
      run_instr(32'h00500093, 0, 0);
      run_instr(32'h00500093, 1, 0);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (observed() !== 11'b000_100_000_00 || instret !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_clears: got %h cnt %0d want %h cnt 0", observed(), instret, 11'b000_100_000_00);
      end
      apply_reset();
   endtask

   task automatic test_alu_decode();
      run_instr(32'h00500093, 0, 0);
      run_instr(32'h402081B3, 0, 0);
      run_instr(32'h4032D293, 1, 0);
      run_instr(32'h40008093, 0, 0);
      run_instr(32'h0020D293, 2, 0);
      run_instr(32'h4020D1B3, 0, 0);
   endtask

   task automatic test_load_store();
      run_instr(32'h0020A223, 0, 3);
      run_instr(32'h0000A203, 1, 2);
      run_instr(32'h0000A003, 0, 0);
   endtask

   task automatic test_illegal();
      run_instr(32'h0000006F, 0, 0);
      apply_reset();
      vectors++;
      if (observed() !== 11'b000_100_000_00) begin
         miscompares++;
         $display("[TB] FAIL illegal_cleared: got %h want %h", observed(), 11'b000_100_000_00);
      end
      run_instr(32'h00500093, 0, 0);
   endtask

   task automatic test_timeout();
      run_instr(32'h00500093, 10, 0);
      apply_reset();
      vectors++;
      if (bus_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bus_err_cleared: got %b want 0", bus_err);
      end
      run_instr(32'h00500093, TMO - 1, 0);
      run_instr(32'h0020A223, 0, TMO - 1);
      run_instr(32'h0000A203, 0, TMO + 2);
      apply_reset();
   endtask

   task automatic test_mid_request_reset();
      mem_ready = 1'b1;
      instr = 32'h0020A223;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (observed() !== 11'b000_100_000_00) begin
         miscompares++;
         $display("[TB] FAIL mid_request_reset: got %h want %h", observed(), 11'b000_100_000_00);
      end
      apply_reset();
      run_instr(32'h0000A203, 0, 1);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 60; n++) begin
         run_instr(rand_instr(), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      end
   endtask

   initial begin
      test_reset();
      test_alu_decode();
      test_load_store();
      test_illegal();
      test_timeout();
      test_mid_request_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
